// File: rtl/pc_fetch_unit_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : pc_fetch_unit_pkg                                    |
// | Description : Shared state encoding and constants for fetch stage  |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
package pc_fetch_unit_pkg;

   typedef enum logic [1:0] {
      S_OFF   = 2'd0,
      S_REQ   = 2'd1,
      S_WAIT  = 2'd2,
      S_VALID = 2'd3
   } fetch_state_e;

   // Only this bit of the CTRL stall vector governs the fetch stage.
   localparam int c_FETCH_STALL_BIT = 0;

endpackage
`default_nettype wire

// File: rtl/pc_fetch_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : pc_fetch_unit_if                                     |
// | Description : Instruction-memory request/grant/rvalid bundle       |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
interface pc_fetch_unit_if #(
   parameter int PC_W   = 32,
   parameter int INST_W = 32
);
   logic              if_req;
   logic [PC_W-1:0]   if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [INST_W-1:0] if_rdata;

   modport master (
      output if_req,
      output if_addr,
      input  if_gnt,
      input  if_rvalid,
      input  if_rdata
   );

   modport slave (
      input  if_req,
      input  if_addr,
      output if_gnt,
      output if_rvalid,
      output if_rdata
   );
endinterface
`default_nettype wire

// File: rtl/pc_fetch_unit_redirect_arb.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : pc_redirect_arb                                      |
// | Description : CP0 > branch > pending > sequential next-PC select   |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
module pc_redirect_arb #(
   parameter int PC_W       = 32,
   parameter int INST_BYTES = 4
) (
   input  wire logic            clk,
   input  wire logic            rst,
   input  wire logic            i_cp0_flag,
   input  wire logic [PC_W-1:0] i_cp0_addr,
   input  wire logic            i_branch_take,
   input  wire logic [PC_W-1:0] i_branch_target,
   input  wire logic            i_advance,
   input  wire logic [PC_W-1:0] i_pc,
   output logic                 o_pc_load,
   output logic [PC_W-1:0]      o_pc_next
);

   logic            r_pend;
   logic [PC_W-1:0] r_pend_addr;
   logic [PC_W-1:0] w_pc_seq;

   // Natural wrap modulo 2^PC_W is intended.
   assign w_pc_seq  = i_pc + PC_W'(INST_BYTES);
   assign o_pc_load = i_cp0_flag | i_advance;

   always_comb begin
      o_pc_next = w_pc_seq;
      if (i_cp0_flag) begin
         o_pc_next = i_cp0_addr;
      end else if (i_branch_take) begin
         o_pc_next = i_branch_target;
      end else if (r_pend) begin
         o_pc_next = r_pend_addr;
      end
   end

   // A branch resolved while the held instruction is not ready to retire is parked here.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pend      <= 1'b0;
         r_pend_addr <= '0;
      end else if (i_cp0_flag || i_advance) begin
         r_pend      <= 1'b0;
      end else if (i_branch_take) begin
         r_pend      <= 1'b1;
         r_pend_addr <= i_branch_target;
      end
   end

endmodule
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : pc_fetch_unit                                        |
// | Description : Fetch-stage PC generator with memory handshake       |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
module pc_fetch_unit
   import pc_fetch_unit_pkg::*;
#(
   parameter int              PC_W       = 32,
   parameter int              INST_W     = 32,
   parameter logic [PC_W-1:0] INIT_PC    = 32'hBFC0_0000,
   parameter int              INST_BYTES = 4,
   parameter int              STALL_W    = 6
) (
   input  wire logic               clk,
   input  wire logic               rst,
   input  wire logic [STALL_W-1:0] stall,
   input  wire logic               branch_flag_i,
   input  wire logic [PC_W-1:0]    branch_target_i,
   input  wire logic               cp0_branch_flag,
   input  wire logic [PC_W-1:0]    cp0_branch_addr,
   pc_fetch_unit_if.master         imem,
   output logic                    ce,
   output logic [PC_W-1:0]         pc,
   output logic                    inst_valid_o,
   output logic [INST_W-1:0]       inst_o,
   output logic [PC_W-1:0]         inst_pc_o
);

   fetch_state_e      r_state, w_state_next;
   logic              r_kill, w_kill_next;
   logic              r_ce;
   logic [PC_W-1:0]   r_pc;
   logic              r_inst_valid, w_inst_valid_next;
   logic [INST_W-1:0] r_inst;
   logic [PC_W-1:0]   r_inst_pc;
   logic              w_capture;
   logic              w_advance;
   logic              w_stall_fetch;
   logic              w_pc_load;
   logic [PC_W-1:0]   w_pc_next;

   assign w_stall_fetch = stall[c_FETCH_STALL_BIT];

   generate
      if (STALL_W > 1) begin : g_unused_stall
         logic w_unused_stall_hi;
         assign w_unused_stall_hi = ^stall[STALL_W-1:1];
      end
   endgenerate

   pc_redirect_arb #(
      .PC_W       (PC_W),
      .INST_BYTES (INST_BYTES)
   ) u_redirect_arb (
      .clk             (clk),
      .rst             (rst),
      .i_cp0_flag      (cp0_branch_flag),
      .i_cp0_addr      (cp0_branch_addr),
      .i_branch_take   (branch_flag_i & ~w_stall_fetch),
      .i_branch_target (branch_target_i),
      .i_advance       (w_advance),
      .i_pc            (r_pc),
      .o_pc_load       (w_pc_load),
      .o_pc_next       (w_pc_next)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_OFF;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next      = r_state;
      w_kill_next       = r_kill;
      w_inst_valid_next = r_inst_valid;
      w_capture         = 1'b0;
      w_advance         = 1'b0;
      case (r_state)
         S_OFF: begin
            w_state_next = S_REQ;
         end
         S_REQ: begin
            if (imem.if_gnt) begin
               w_state_next = S_WAIT;
               w_kill_next  = cp0_branch_flag;
            end
         end
         S_WAIT: begin
            if (imem.if_rvalid) begin
               if (r_kill || cp0_branch_flag) begin
                  w_kill_next  = 1'b0;
                  w_state_next = S_REQ;
               end else begin
                  w_capture         = 1'b1;
                  w_inst_valid_next = 1'b1;
                  w_state_next      = S_VALID;
               end
            end else if (cp0_branch_flag) begin
               // Response for the abandoned address is still owed; drop it on arrival.
               w_kill_next = 1'b1;
            end
         end
         S_VALID: begin
            if (cp0_branch_flag) begin
               w_inst_valid_next = 1'b0;
               w_state_next      = S_REQ;
            end else if (!w_stall_fetch) begin
               w_advance         = 1'b1;
               w_inst_valid_next = 1'b0;
               w_state_next      = S_REQ;
            end
         end
         default: begin
            w_state_next = S_OFF;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_kill       <= 1'b0;
         r_ce         <= 1'b0;
         r_pc         <= INIT_PC;
         r_inst_valid <= 1'b0;
         r_inst       <= '0;
         r_inst_pc    <= '0;
      end else begin
         r_kill       <= w_kill_next;
         r_ce         <= 1'b1;
         r_inst_valid <= w_inst_valid_next;
         if (w_pc_load) begin
            r_pc <= w_pc_next;
         end
         if (w_capture) begin
            r_inst    <= imem.if_rdata;
            r_inst_pc <= r_pc;
         end
      end
   end

   assign imem.if_req  = (r_state == S_REQ);
   assign imem.if_addr = r_pc;
   assign ce           = r_ce;
   assign pc           = r_pc;
   assign inst_valid_o = r_inst_valid;
   assign inst_o       = r_inst;
   assign inst_pc_o    = r_inst_pc;

endmodule
`default_nettype wire
